// File: rtl/dsram_responder.sv
// ---------------------------------------------------------------------------
// dsram_responder
//
// Responder end of the CPU data SRAM-like bus (req / addr_ok / data_ok
// handshake). It backs one on-chip scratchpad window of 2^ADDR_W 32-bit
// words and answers each accepted request after a fixed latency of LAT
// cycles. Only one request is outstanding at a time, so responses are
// always in order.
//
// Parameters:
//   ADDR_W     word-address bits of the scratchpad
//   LAT        cycles from the accept edge to the data_ok cycle (1..15)
//   BASE_ADDR  window base; only bits [31:ADDR_W+2] are compared
//
// Ports:
//   Clk                clock, rising edge
//   resetn             asynchronous active-low reset
//   data_sram_req      request valid
//   data_sram_wr       1 = write, 0 = read
//   data_sram_size     0 = byte, 1 = half, 2 = word, 3 = illegal
//   data_sram_addr     byte address
//   data_sram_wstrb    lane-aligned byte write mask
//   data_sram_wdata    lane-aligned write data
//   data_sram_addr_ok  request accepted when high together with req
//   data_sram_data_ok  one-cycle response pulse
//   data_sram_rdata    read data, held between responses
//   data_sram_err      error flag, only ever high with data_ok
//   busy               a request is outstanding
// ---------------------------------------------------------------------------
module dsram_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          LAT       = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Countdown preload for WAIT; unused when LAT==1 (accept goes straight to RESP).
    localparam logic [3:0] CNT_INIT = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

    state_t              state;
    logic [3:0]          cnt;
    logic                wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q;
    logic                fault_q;

    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                out_of_window;
    logic                misaligned;
    logic                fault_now;
    logic                enter_resp;
    logic                acc_wr;
    logic                acc_fault;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_wstrb;
    logic [31:0]         acc_wdata;

    assign data_sram_addr_ok = (state == IDLE);
    assign busy              = (state != IDLE);
    assign accept            = (state == IDLE) && data_sram_req;

    // Fault classification of the live request, evaluated on the accept edge.
    assign out_of_window = (data_sram_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    assign misaligned    = (data_sram_size == 2'd3) ||
                           ((data_sram_size == 2'd1) && data_sram_addr[0]) ||
                           ((data_sram_size == 2'd2) && (data_sram_addr[1:0] != 2'b00));
    assign fault_now     = out_of_window || misaligned;

    // The memory access happens on the edge that enters RESP. With LAT==1 that
    // edge is the accept edge itself, so the access must use the live inputs
    // rather than the (not yet loaded) captured copies.
    assign enter_resp = (accept && (LAT == 1)) || ((state == WAIT) && (cnt == 4'd0));
    assign acc_wr     = (state == IDLE) ? data_sram_wr                       : wr_q;
    assign acc_fault  = (state == IDLE) ? fault_now                          : fault_q;
    assign acc_idx    = (state == IDLE) ? data_sram_addr[ADDR_W+1:2]         : idx_q;
    assign acc_wstrb  = (state == IDLE) ? data_sram_wstrb                    : wstrb_q;
    assign acc_wdata  = (state == IDLE) ? data_sram_wdata                    : wdata_q;

    // Handshake FSM with registered response outputs. Reset drops any
    // outstanding request outright; the response registers also capture read
    // data on the access edge.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            cnt               <= 4'd0;
            wr_q              <= 1'b0;
            idx_q             <= '0;
            wstrb_q           <= 4'd0;
            wdata_q           <= 32'd0;
            fault_q           <= 1'b0;
            data_sram_data_ok <= 1'b0;
            data_sram_rdata   <= 32'd0;
            data_sram_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= data_sram_wr;
                        idx_q   <= data_sram_addr[ADDR_W+1:2];
                        wstrb_q <= data_sram_wstrb;
                        wdata_q <= data_sram_wdata;
                        fault_q <= fault_now;
                        cnt     <= CNT_INIT;
                        state   <= (LAT == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    data_sram_data_ok <= 1'b0;
                    data_sram_err     <= 1'b0;
                    state             <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (enter_resp) begin
                data_sram_data_ok <= 1'b1;
                data_sram_err     <= acc_fault;
                if (!acc_wr) begin
                    data_sram_rdata <= acc_fault ? 32'd0 : mem[acc_idx];
                end
            end
        end
    end

    // Scratchpad storage, deliberately not reset. Writes land on the access
    // edge only, so a write interrupted by reset never reaches memory.
    always_ff @(posedge Clk) begin
        if (enter_resp && acc_wr && !acc_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
